instruction_fetch_stage: RTL and testbench

Fetch stage of the pipelined RISC-V core, directly upstream of the instruction memory and feeding the decode stage. It owns the program counter and drives the word-indexed instruction memory address. It captures the returned instruction into the IF/ID pipeline register, with stall, branch/jump redirect and flush handling. It also contains a small control FSM that stops fetching at the end of instruction memory or on a misaligned redirect.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/if_id_register.sv | 33 +++
 rtl/instruction_fetch_stage.sv | 97 +++++++++
 tb/tb_instruction_fetch_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V pipeline front end.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush inserts a bubble and keeps the PC fields, load captures, otherwise hold.
module if_id_register
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t q_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q.valid    <= 1'b0;
      q_q.pc       <= '0;
      q_q.pc_plus4 <= '0;
      q_q.instr    <= NOP_INSTR;
    end else if (flush) begin
      q_q.valid <= 1'b0;
      q_q.instr <= NOP_INSTR;
    end else if (load) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, drives instruction memory, fills IF/ID and stops at end of memory or on misaligned redirect.
module instruction_fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 32,
  parameter logic [31:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] instruction_addr,
  input  logic [31:0] instruction_read,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        halted,
  output logic        misaligned_fault
);

  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4;
  logic         redirect_act;
  logic         ifid_load, ifid_flush;
  if_id_t       ifid_d, ifid_q;

  assign pc_plus4     = pc_q + 32'd4;
  assign redirect_act = redirect_valid && (state_q != FAULT);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (redirect_act) begin
      ifid_flush = 1'b1;
      if (redirect_target[1:0] != 2'b00) begin
        state_d = FAULT;
      end else if (redirect_target >= IMEM_BYTES) begin
        state_d = HALT;
      end else begin
        pc_d    = redirect_target;
        state_d = RUN;
      end
    end else if (!stall) begin
      if (state_q == RUN) begin
        ifid_load = 1'b1;
        // The last word is still captured; only the PC stops advancing.
        if (pc_plus4 >= IMEM_BYTES) begin
          state_d = HALT;
        end else begin
          pc_d = pc_plus4;
        end
      end else begin
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign ifid_d = '{valid: 1'b1, pc: pc_q, pc_plus4: pc_plus4, instr: instruction_read};

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (ifid_load),
    .flush   (ifid_flush),
    .d       (ifid_d),
    .q       (ifid_q)
  );

  assign instruction_addr = pc_q;
  assign if_id_valid      = ifid_q.valid;
  assign if_id_pc         = ifid_q.pc;
  assign if_id_pc_plus4   = ifid_q.pc_plus4;
  assign if_id_instr      = ifid_q.instr;
  assign halted           = (state_q != RUN);
  assign misaligned_fault = (state_q == FAULT);

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: behavioural model checked every cycle plus directed literal checks.
module tb_instruction_fetch_stage;

  localparam int unsigned WORDS = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instruction_addr;
  logic [31:0] instruction_read;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        halted;
  logic        misaligned_fault;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (WORDS),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .instruction_addr (instruction_addr),
    .instruction_read (instruction_read),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .if_id_valid      (if_id_valid),
    .if_id_pc         (if_id_pc),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_instr      (if_id_instr),
    .halted           (halted),
    .misaligned_fault (misaligned_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
    return 32'hA000_0000 + (byte_addr / 4);
  endfunction

  assign instruction_read = mem_word(instruction_addr);

  // Reference model: mode 0 = fetching, 1 = stopped at end, 2 = stopped on fault.
  logic [31:0] m_pc;
  int          m_mode;
  logic        m_valid;
  logic [31:0] m_ipc, m_ip4, m_instr;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc = 32'h0; m_mode = 0;
      m_valid = 1'b0; m_ipc = 32'h0; m_ip4 = 32'h0; m_instr = NOP;
    end else if (redirect_valid && m_mode != 2) begin
      m_valid = 1'b0; m_instr = NOP;
      if (redirect_target % 4 != 0) m_mode = 2;
      else if (redirect_target >= WORDS * 4) m_mode = 1;
      else begin m_pc = redirect_target; m_mode = 0; end
    end else if (stall) begin
      // everything holds
    end else if (m_mode == 0) begin
      m_valid = 1'b1; m_ipc = m_pc; m_ip4 = m_pc + 4; m_instr = mem_word(m_pc);
      if (m_pc + 4 >= WORDS * 4) m_mode = 1;
      else m_pc = m_pc + 4;
    end else begin
      m_valid = 1'b0; m_instr = NOP;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model.addr",    instruction_addr, m_pc);
    chk("model.valid",   {31'b0, if_id_valid}, {31'b0, m_valid});
    chk("model.pc",      if_id_pc, m_ipc);
    chk("model.pc4",     if_id_pc_plus4, m_ip4);
    chk("model.instr",   if_id_instr, m_instr);
    chk("model.halted",  {31'b0, halted}, {31'b0, m_mode != 0});
    chk("model.fault",   {31'b0, misaligned_fault}, {31'b0, m_mode == 2});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    step(2);
    chk("rst.valid", {31'b0, if_id_valid}, 32'd0);
    chk("rst.instr", if_id_instr, NOP);
    chk("rst.pc",    if_id_pc, 32'h0);
    chk("rst.halt",  {31'b0, halted}, 32'd0);
    reset_n = 1'b1;
    step(1);
    chk("f1.pc",    if_id_pc, 32'h0);
    chk("f1.instr", if_id_instr, 32'hA000_0000);
    step(1);
    chk("f2.pc",    if_id_pc, 32'h4);
    chk("f2.instr", if_id_instr, 32'hA000_0001);
    chk("f2.addr",  instruction_addr, 32'h8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall.pc", if_id_pc, 32'h4);
    end
    stall = 1'b0;
    step(1);
    chk("unstall.pc",    if_id_pc, 32'h8);
    chk("unstall.instr", if_id_instr, 32'hA000_0002);
    step(1);
    chk("pre_redir.addr", instruction_addr, 32'h10);
    redirect_valid = 1'b1; redirect_target = 32'h40; stall = 1'b1;
    step(1);
    redirect_valid = 1'b0; stall = 1'b0;
    chk("redir.bubble_v", {31'b0, if_id_valid}, 32'd0);
    chk("redir.bubble_i", if_id_instr, NOP);
    step(1);
    chk("redir.pc",    if_id_pc, 32'h40);
    chk("redir.instr", if_id_instr, 32'hA000_0010);
    step(15);
    chk("end.pc",    if_id_pc, 32'h7C);
    chk("end.instr", if_id_instr, 32'hA000_001F);
    chk("end.pc4",   if_id_pc_plus4, 32'h80);
    chk("end.halt",  {31'b0, halted}, 32'd1);
    step(1);
    chk("end.bubble", {31'b0, if_id_valid}, 32'd0);
    chk("end.addr",   instruction_addr, 32'h7C);
    redirect_valid = 1'b1; redirect_target = 32'h0;
    step(1);
    redirect_valid = 1'b0;
    chk("resume.halt", {31'b0, halted}, 32'd0);
    step(1);
    chk("resume.pc",    if_id_pc, 32'h0);
    chk("resume.instr", if_id_instr, 32'hA000_0000);
    redirect_valid = 1'b1; redirect_target = 32'h42;
    step(1);
    redirect_valid = 1'b0;
    chk("mis.fault", {31'b0, misaligned_fault}, 32'd1);
    chk("mis.halt",  {31'b0, halted}, 32'd1);
    chk("mis.addr",  instruction_addr, 32'h4);
    step(2);
    chk("mis.bubble", {31'b0, if_id_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_target = 32'h0;
    step(1);
    redirect_valid = 1'b0;
    chk("mis.ignored", {31'b0, misaligned_fault}, 32'd1);
    chk("mis.addr2",   instruction_addr, 32'h4);
    reset_n = 1'b0;
    #1;
    chk("async.fault", {31'b0, misaligned_fault}, 32'd0);
    chk("async.addr",  instruction_addr, 32'h0);
    step(1);
    reset_n = 1'b1;
    step(1);
    chk("rerun.pc",    if_id_pc, 32'h0);
    chk("rerun.valid", {31'b0, if_id_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_target = 32'h80;
    step(1);
    redirect_valid = 1'b0;
    chk("oor.halt",  {31'b0, halted}, 32'd1);
    chk("oor.fault", {31'b0, misaligned_fault}, 32'd0);
    chk("oor.addr",  instruction_addr, 32'h4);
    stall = 1'b1;
    step(2);
    stall = 1'b0;
    step(2);
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
